// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pkg
// Purpose  : Shared defaults, magnitude limit and pixel-position type for the
//            Sobel magnitude block.
// Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

  localparam int WIDTH_D   = 8;
  localparam int DEPTH_D   = 16;
  localparam int HEIGHT_D  = 16;
  localparam int MAG_MAX_D = (1 << WIDTH_D) - 1;

  // Position fields are held wide so any legal frame geometry fits.
  localparam int POS_W = 16;

  typedef struct packed {
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
    logic             last;
  } pos_t;

endpackage
`default_nettype wire

// File: rtl/elastic_reg.sv
`default_nettype none
// ============================================================================
// Module   : elastic_reg
// Purpose  : One valid/ready pipeline register; loads when empty or drained.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_reg
  import sobel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign ready_o = ~r_valid | ready_i;
  assign valid_o = r_valid;
  assign data_o  = r_data;

  // Data only moves on a real transfer so a stalled output stays frozen.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (ready_o) begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_data <= data_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_magnitude.sv
`default_nettype none
// ============================================================================
// Module   : sobel_magnitude
// Purpose  : Two-stage elastic |gx|+|gy| magnitude with saturation, 3x3
//            border masking, edge threshold and end-of-frame tagging.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_magnitude
  import sobel_pkg::*;
#(
  parameter int WIDTH_P  = WIDTH_D,
  parameter int DEPTH_P  = DEPTH_D,
  parameter int HEIGHT_P = HEIGHT_D
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic        [WIDTH_P-1:0]   thresh_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic        [WIDTH_P-1:0]   mag_o,
  output logic                        edge_o,
  output logic                        last_o
);

  localparam int ABS_W = 2 * WIDTH_P;
  localparam int COL_W = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
  localparam int ROW_W = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

  localparam logic [COL_W-1:0]   C_COL_LAST    = COL_W'(DEPTH_P - 1);
  localparam logic [ROW_W-1:0]   C_ROW_LAST    = ROW_W'(HEIGHT_P - 1);
  localparam logic [WIDTH_P-1:0] C_MAG_MAX     = '1;
  localparam logic [ABS_W:0]     C_MAG_MAX_EXT = (ABS_W + 1)'(C_MAG_MAX);

  typedef struct packed {
    logic [ABS_W-1:0] abs_gx;
    logic [ABS_W-1:0] abs_gy;
    pos_t             pos;
  } s1_t;

  typedef struct packed {
    logic [WIDTH_P-1:0] mag;
    logic               is_edge;
    logic               last;
  } s2_t;

  // Two's-complement negate in the unsigned domain: -2^(N-1) maps to 2^(N-1).
  function automatic logic [ABS_W-1:0] abs_val(input logic signed [ABS_W-1:0] v);
    logic [ABS_W-1:0] u;
    u = $unsigned(v);
    return u[ABS_W-1] ? (~u + ABS_W'(1)) : u;
  endfunction

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_accept;

  s1_t              w_s1_d;
  s1_t              w_s1_q;
  logic             w_s1_valid;
  logic             w_s2_ready;

  s2_t              w_s2_d;
  s2_t              w_s2_q;
  logic [ABS_W:0]   w_sum;
  logic             w_border;
  logic [WIDTH_P-1:0] w_mag;

  assign w_accept = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == C_COL_LAST) begin
        r_col <= '0;
        if (r_row == C_ROW_LAST) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  always_comb begin
    w_s1_d          = '0;
    w_s1_d.abs_gx   = abs_val(gx_i);
    w_s1_d.abs_gy   = abs_val(gy_i);
    w_s1_d.pos.row  = POS_W'(r_row);
    w_s1_d.pos.col  = POS_W'(r_col);
    w_s1_d.pos.last = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);
  end

  elastic_reg #(
    .WIDTH ($bits(s1_t))
  ) u_s1 (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (w_s1_d),
    .valid_o (w_s1_valid),
    .ready_i (w_s2_ready),
    .data_o  (w_s1_q)
  );

  // Threshold is applied here, so it is sampled as the pixel enters S2.
  always_comb begin
    w_sum    = {1'b0, w_s1_q.abs_gx} + {1'b0, w_s1_q.abs_gy};
    w_border = (w_s1_q.pos.row < POS_W'(2)) || (w_s1_q.pos.col < POS_W'(2));
    w_mag    = '0;
    if (!w_border) begin
      w_mag = (w_sum > C_MAG_MAX_EXT) ? C_MAG_MAX : w_sum[WIDTH_P-1:0];
    end
    w_s2_d         = '0;
    w_s2_d.mag     = w_mag;
    w_s2_d.is_edge = (w_mag > thresh_i);
    w_s2_d.last    = w_s1_q.pos.last;
  end

  elastic_reg #(
    .WIDTH ($bits(s2_t))
  ) u_s2 (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (w_s1_valid),
    .ready_o (w_s2_ready),
    .data_i  (w_s2_d),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (w_s2_q)
  );

  assign mag_o  = w_s2_q.mag;
  assign edge_o = w_s2_q.is_edge;
  assign last_o = w_s2_q.last;

endmodule
`default_nettype wire

// File: tb/tb_sobel_magnitude.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_magnitude
// Purpose  : Directed self-checking bench for sobel_magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_magnitude;

  logic               clk = 1'b0;
  logic               rstn_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [15:0] gx_i;
  logic signed [15:0] gy_i;
  logic        [7:0]  thresh_i;
  logic               valid_o;
  logic               ready_i;
  logic        [7:0]  mag_o;
  logic               edge_o;
  logic               last_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc;

  logic [9:0] q[$];
  int         qc[$];

  sobel_magnitude #(
    .WIDTH_P  (8),
    .DEPTH_P  (16),
    .HEIGHT_P (16)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .gx_i     (gx_i),
    .gy_i     (gy_i),
    .thresh_i (thresh_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .mag_o    (mag_o),
    .edge_o   (edge_o),
    .last_o   (last_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer as {last, edge, mag} with its cycle.
  always @(negedge clk) begin
    if (rstn_i && valid_o && ready_i) begin
      q.push_back({last_o, edge_o, mag_o});
      qc.push_back(cyc);
    end
  end

  task automatic do_reset();
    valid_i = 1'b0;
    ready_i = 1'b1;
    gx_i    = '0;
    gy_i    = '0;
    rstn_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
    q.delete();
    qc.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [15:0] gx, input logic signed [15:0] gy);
    bit done;
    done    = 1'b0;
    valid_i = 1'b1;
    gx_i    = gx;
    gy_i    = gy;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (ready_o) begin
        acc_cyc = cyc;
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready_o=%0b, required 1 within 200 cycles", ready_o);
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) push(16'sd0, 16'sd0);
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 400 && q.size() < n; i++) @(posedge clk);
    #1;
    if (q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_out_timeout: got %0d outputs, required %0d", q.size(), n);
    end
  endtask

  task automatic test_reset();
    rstn_i   = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    gx_i     = '0;
    gy_i     = '0;
    thresh_i = 8'd0;
    #2;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %0b, required 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_o: got %0b, required 1", ready_o); end
    checks++; if (mag_o !== 8'd0) begin errors++; $display("FAIL reset_mag_o: got %0d, required 0", mag_o); end
    checks++; if ({edge_o, last_o} !== 2'b00) begin errors++; $display("FAIL reset_edge_last: got %b, required 00", {edge_o, last_o}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %0b, required 1", ready_o); end
  endtask

  task automatic test_saturate();
    int lat;
    do_reset();
    thresh_i = 8'd128;
    fill(34);
    push(-16'sd300, 16'sd100);
    lat = acc_cyc;
    wait_out(35);
    if (q.size() >= 35) begin
      checks++; if (q[34] !== {1'b0, 1'b1, 8'd255}) begin errors++; $display("FAIL saturate_400: got %h, required %h", q[34], {1'b0, 1'b1, 8'd255}); end
      checks++; if (qc[34] - lat !== 2) begin errors++; $display("FAIL latency: got %0d cycles, required 2", qc[34] - lat); end
      checks++; if (q[33] !== 10'h000) begin errors++; $display("FAIL border_idx33: got %h, required 000", q[33]); end
    end
  endtask

  task automatic test_threshold();
    do_reset();
    thresh_i = 8'd50;
    fill(34);
    push(16'sd30, -16'sd20);
    repeat (4) @(posedge clk);
    #1;
    thresh_i = 8'd49;
    push(16'sd30, -16'sd20);
    wait_out(36);
    if (q.size() >= 36) begin
      checks++; if (q[34] !== {1'b0, 1'b0, 8'd50}) begin errors++; $display("FAIL thresh_equal: got %h, required %h", q[34], {1'b0, 1'b0, 8'd50}); end
      checks++; if (q[35] !== {1'b0, 1'b1, 8'd50}) begin errors++; $display("FAIL thresh_below: got %h, required %h", q[35], {1'b0, 1'b1, 8'd50}); end
    end
  endtask

  task automatic test_most_negative();
    do_reset();
    thresh_i = 8'd0;
    fill(34);
    push(16'sh8000, 16'sd0);
    wait_out(35);
    if (q.size() >= 35) begin
      checks++; if (q[34] !== {1'b0, 1'b1, 8'd255}) begin errors++; $display("FAIL most_negative: got %h, required %h", q[34], {1'b0, 1'b1, 8'd255}); end
    end
  endtask

  task automatic test_frame();
    logic [9:0] exp_v;
    logic [7:0] exp_m;
    do_reset();
    thresh_i = 8'd128;
    for (int i = 0; i < 256; i++) push(16'sd100, 16'sd100);
    wait_out(256);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (q.size() !== 256) begin errors++; $display("FAIL frame_count: got %0d, required 256", q.size()); end
    if (q.size() >= 256) begin
      for (int i = 0; i < 256; i++) begin
        exp_m = ((i / 16) < 2 || (i % 16) < 2) ? 8'd0 : 8'd200;
        exp_v = {(i == 255), (exp_m > 8'd128), exp_m};
        checks++;
        if (q[i] !== exp_v) begin
          errors++;
          $display("FAIL frame_pixel_%0d: got %h, required %h", i, q[i], exp_v);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_m;
    logic [9:0] exp_v;
    do_reset();
    thresh_i = 8'd25;
    fill(34);
    wait_out(34);
    ready_i = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) push(16'(10 * (k + 1)), 16'sd0);
      end
      begin
        repeat (3) @(negedge clk);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid_o: got %0b, required 1", valid_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready_o: got %0b, required 0", ready_o); end
        for (int s = 0; s < 3; s++) begin
          if (s > 0) @(negedge clk);
          checks++;
          if ({valid_o, last_o, edge_o, mag_o} !== {1'b1, 1'b0, 1'b0, 8'd10}) begin
            errors++;
            $display("FAIL stall_stable_%0d: got v=%0b l=%0b e=%0b m=%0d, required v=1 l=0 e=0 m=10",
                     s, valid_o, last_o, edge_o, mag_o);
          end
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    wait_out(42);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (q.size() !== 42) begin errors++; $display("FAIL stall_count: got %0d, required 42", q.size()); end
    if (q.size() >= 42) begin
      for (int k = 0; k < 8; k++) begin
        exp_m = 8'(10 * (k + 1));
        exp_v = {1'b0, (exp_m > 8'd25), exp_m};
        checks++;
        if (q[34 + k] !== exp_v) begin
          errors++;
          $display("FAIL stall_order_%0d: got %h, required %h", k, q[34 + k], exp_v);
        end
      end
    end
  endtask

  task automatic test_reset_midrow();
    do_reset();
    thresh_i = 8'd0;
    for (int i = 0; i < 7; i++) push(16'sd100, 16'sd100);
    valid_i = 1'b1;
    gx_i    = 16'sd100;
    gy_i    = 16'sd100;
    @(negedge clk);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL midrow_pre_valid: got %0b, required 1", valid_o); end
    rstn_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrow_async_valid: got %0b, required 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrow_ready: got %0b, required 1", ready_o); end
    checks++; if ({last_o, edge_o, mag_o} !== 10'h000) begin errors++; $display("FAIL midrow_outputs: got %h, required 000", {last_o, edge_o, mag_o}); end
    valid_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    q.delete();
    qc.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 35; i++) push(16'sd100, 16'sd100);
    wait_out(35);
    if (q.size() >= 35) begin
      checks++; if (q[0] !== 10'h000) begin errors++; $display("FAIL midrow_first: got %h, required 000", q[0]); end
      checks++; if (q[33] !== 10'h000) begin errors++; $display("FAIL midrow_idx33: got %h, required 000", q[33]); end
      checks++; if (q[34] !== {1'b0, 1'b1, 8'd200}) begin errors++; $display("FAIL midrow_idx34: got %h, required %h", q[34], {1'b0, 1'b1, 8'd200}); end
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_threshold();
    test_most_negative();
    test_frame();
    test_backpressure();
    test_reset_midrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_magnitude.md
SOBEL_MAGNITUDE -- requirements
Module: sobel_magnitude

Interface
REQ-001 WIDTH_P, 8, pixel width; gradient inputs are 2*WIDTH_P signed.
REQ-002 DEPTH_P, 16, pixels per image row (line length).
REQ-003 HEIGHT_P, 16, rows per frame.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 valid_i  input  1  upstream gradient pair valid.
REQ-007 ready_o  output  1  block can accept a gradient pair this cycle.
REQ-008 gx_i  input  2*WIDTH_P signed  horizontal Sobel gradient.
REQ-009 gy_i  input  2*WIDTH_P signed  vertical Sobel gradient.
REQ-010 thresh_i  input  WIDTH_P  edge threshold, unsigned, quasi-static.
REQ-011 valid_o  output  1  output pixel valid.
REQ-012 ready_i  input  1  downstream accepts output this cycle.
REQ-013 mag_o  output  WIDTH_P  saturated gradient magnitude.
REQ-014 edge_o  output  1  mag_o strictly greater than thresh_i.
REQ-015 last_o  output  1  pixel is last of frame (row HEIGHT_P-1, col DEPTH_P-1).

Function
REQ-016 Input transfer occurs when valid_i & ready_o; output transfer when valid_o & ready_i.
REQ-017 Two-stage elastic pipeline: S1 = |gx|,|gy| plus position flags; S2 = sum, saturate, border mask, threshold.
REQ-018 Each stage loads when empty or its contents are transferred downstream that cycle; ready_o = ~S1.valid | S1 advancing.
REQ-019 With ready_i held high, latency is exactly 2 cycles (accept at N, valid_o at N+2); throughput 1 pixel/cycle.
REQ-020 While valid_o & ~ready_i, mag_o, edge_o, last_o and valid_o remain stable.
REQ-021 Absolute values computed as 2*WIDTH_P-bit unsigned; most-negative input (-2^(2*WIDTH_P-1)) yields 2^(2*WIDTH_P-1) with no overflow.
REQ-022 Sum |gx|+|gy| computed at 2*WIDTH_P+1 bits; mag_o = min(sum, 2^WIDTH_P-1).
REQ-023 Column counter 0..DEPTH_P-1 and row counter 0..HEIGHT_P-1 advance on each input transfer only.
REQ-024 Column wraps DEPTH_P-1 -> 0 and increments row; row wraps HEIGHT_P-1 -> 0 at the same transfer (frame end).
REQ-025 Pixels with column < 2 or row < 2 (incomplete 3x3 window) output mag_o = 0 and edge_o = 0 but are still emitted.
REQ-026 edge_o = (mag_o > thresh_i), thresh_i sampled when the pixel enters S2.
REQ-027 last_o tags the pixel accepted at (row HEIGHT_P-1, col DEPTH_P-1); zero otherwise.
REQ-028 Simultaneous input and output transfer with both stages full SHALL neither drop nor duplicate a pixel.

Reset
REQ-029 On rstn_i low, asynchronously: valid_o=0, S1/S2 valid=0, mag_o=0, edge_o=0, last_o=0, counters=0.
REQ-030 ready_o SHALL be 1 in reset and in the first cycle after release.
REQ-031 Reset mid-frame discards in-flight pixels; next accepted pixel is (row 0, col 0).

Structure
REQ-032 Shared package sobel_pkg holds WIDTH_P/DEPTH_P/HEIGHT_P defaults, magnitude max constant, and a pixel-position struct (row, col, last).
REQ-033 One sub-module, elastic_reg (valid/ready register stage, parameterised width), instantiated for S1 and S2.
REQ-034 Counter widths are $clog2 of DEPTH_P and HEIGHT_P.

Verification
REQ-035 Interior pixel, thresh_i=128, gx=-300, gy=100 -> sum 400, mag_o=255, edge_o=1, valid_o 2 cycles after accept.
REQ-036 Interior pixel, thresh_i=50, gx=30, gy=-20 -> mag_o=50, edge_o=0 (strict compare); thresh_i=49 -> edge_o=1.
REQ-037 Full 16x16 frame, gx=gy=100 constant -> indices 0-33 and every col 0/1 give mag_o=0; index 34 gives 200; index 255 has last_o=1 only.
REQ-038 Stream with ready_i low 5 cycles -> outputs stable, ready_o low after 2 pixels buffered, no loss/duplication on release (scoreboard).
REQ-039 gx=-32768, gy=0 at interior -> mag_o=255, edge_o=1 for thresh_i=0.
REQ-040 rstn_i asserted mid-row (col 7) -> valid_o drops immediately; next pixel treated as (0,0), mag_o=0.
